// File: rtl/led_bcm_scheduler_pkg.sv
// Shared definitions for the HUB75 BCM scheduler: FSM encodings, panel
// geometry and the bit-plane weighting used to size on-time.
package led_bcm_scheduler_pkg;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_FILL    = 5'b00010,
    S_LATCH   = 5'b00100,
    S_DISPLAY = 5'b01000,
    S_BLANK   = 5'b10000
  } state_e;

  localparam int ADDR_BITS = 5;
  localparam int COLUMNS   = 64;

  // On-time of bit-plane p in clk cycles.
  function automatic int unsigned plane_weight(input int unsigned base_ticks,
                                               input int unsigned plane);
    return base_ticks << plane;
  endfunction

endpackage

// File: rtl/led_bcm_scheduler_slot_counter.sv
// {addr,plane} slot pointer: plane advances fastest, then row address,
// wrapping from the last slot back to (0,0).
module bcm_slot_counter #(
  parameter int PLANES    = 8,
  parameter int ADDR_BITS = 5,
  localparam int PW       = $clog2(PLANES)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 advance,
  output logic [ADDR_BITS-1:0] addr,
  output logic [PW-1:0]        plane,
  output logic                 at_origin
);
  import led_bcm_scheduler_pkg::*;

  logic [ADDR_BITS-1:0] addr_r;
  logic [PW-1:0]        plane_r;
  logic [ADDR_BITS-1:0] next_addr_s;
  logic [PW-1:0]        next_plane_s;

  // Look-ahead to the slot after the current one; address wraps naturally.
  always_comb begin
    next_addr_s  = addr_r;
    next_plane_s = plane_r;
    if (plane_r == PW'(PLANES - 1)) begin
      next_plane_s = {PW{1'b0}};
      next_addr_s  = addr_r + ADDR_BITS'(1);
    end else begin
      next_plane_s = plane_r + PW'(1);
      next_addr_s  = addr_r;
    end
  end

  // Pointer register: cleared on a fresh start, stepped on each new request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_r  <= {ADDR_BITS{1'b0}};
      plane_r <= {PW{1'b0}};
    end else if (clear) begin
      addr_r  <= {ADDR_BITS{1'b0}};
      plane_r <= {PW{1'b0}};
    end else if (advance) begin
      addr_r  <= next_addr_s;
      plane_r <= next_plane_s;
    end else begin
      addr_r  <= addr_r;
      plane_r <= plane_r;
    end
  end

  assign addr      = addr_r;
  assign plane     = plane_r;
  assign at_origin = (addr_r == {ADDR_BITS{1'b0}}) && (plane_r == {PW{1'b0}});

endmodule

// File: rtl/led_bcm_scheduler.sv
// HUB75 binary-coded-modulation scheduler: overlaps the column shift of the
// next slot with the on-time of the current one and drives blank/latch/addr.
module led_bcm_scheduler #(
  parameter int PLANES     = 8,
  parameter int ADDR_BITS  = led_bcm_scheduler_pkg::ADDR_BITS,
  parameter int BASE_TICKS = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  output logic                       shift_req,
  output logic [ADDR_BITS-1:0]       shift_addr,
  output logic [$clog2(PLANES)-1:0]  shift_plane,
  input  logic                       shift_done,
  output logic                       led_blank,
  output logic                       led_latch,
  output logic [ADDR_BITS-1:0]       led_addr,
  output logic                       frame_start,
  output logic                       busy
);
  import led_bcm_scheduler_pkg::*;

  localparam int PW = $clog2(PLANES);
  localparam int TW = $clog2(BASE_TICKS) + PLANES;

  state_e               state_r, state_nxt;
  logic [TW-1:0]        timer_r;
  logic                 pending_r, done_flag_r;
  logic                 shift_req_r, led_blank_r, led_latch_r, frame_start_r, busy_r;
  logic [ADDR_BITS-1:0] led_addr_r;
  logic                 start_req_s, next_req_s, at_origin_s;
  logic [ADDR_BITS-1:0] slot_addr_s;
  logic [PW-1:0]        slot_plane_s;

  // The pointer always names the most recently requested slot, which is
  // also the slot the next LATCH presents.
  assign start_req_s = (state_r == S_IDLE) && enable;
  assign next_req_s  = (state_r == S_LATCH) && enable;

  bcm_slot_counter #(
    .PLANES    (PLANES),
    .ADDR_BITS (ADDR_BITS)
  ) u_slot (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (start_req_s),
    .advance   (next_req_s),
    .addr      (slot_addr_s),
    .plane     (slot_plane_s),
    .at_origin (at_origin_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE:    if (enable) state_nxt = S_FILL; else state_nxt = S_IDLE;
      S_FILL:    if (shift_done) state_nxt = S_LATCH; else state_nxt = S_FILL;
      S_LATCH:   state_nxt = S_DISPLAY;
      S_DISPLAY: if (timer_r == {TW{1'b0}}) state_nxt = S_BLANK; else state_nxt = S_DISPLAY;
      S_BLANK: begin
        if (!pending_r)                     state_nxt = S_IDLE;
        else if (done_flag_r || shift_done) state_nxt = S_LATCH;
        else                                state_nxt = S_BLANK;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= S_IDLE;
    else         state_r <= state_nxt;
  end

  // Pin-facing outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_blank_r   <= 1'b1;
      led_latch_r   <= 1'b0;
      led_addr_r    <= {ADDR_BITS{1'b0}};
      frame_start_r <= 1'b0;
      busy_r        <= 1'b0;
      shift_req_r   <= 1'b0;
    end else begin
      led_blank_r   <= (state_nxt != S_DISPLAY);
      led_latch_r   <= (state_nxt == S_LATCH);
      frame_start_r <= (state_nxt == S_LATCH) && at_origin_s;
      busy_r        <= (state_nxt != S_IDLE);
      shift_req_r   <= start_req_s || next_req_s;
      if (state_nxt == S_LATCH) led_addr_r <= slot_addr_s;
      else                      led_addr_r <= led_addr_r;
    end
  end

  // Timer is loaded during LATCH and counts the DISPLAY cycles down to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_r <= {TW{1'b0}};
    end else if (state_r == S_LATCH) begin
      timer_r <= TW'(plane_weight(BASE_TICKS, 32'(slot_plane_s)) - 32'd1);
    end else if ((state_r == S_DISPLAY) && (timer_r != {TW{1'b0}})) begin
      timer_r <= timer_r - TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // An early shift_done is remembered so BLANK only lasts the minimum dead time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_r   <= 1'b0;
      done_flag_r <= 1'b0;
    end else begin
      if (state_r == S_LATCH)        pending_r <= enable;
      else if (state_nxt == S_IDLE)  pending_r <= 1'b0;
      else                           pending_r <= pending_r;

      if (state_nxt == S_LATCH)
        done_flag_r <= 1'b0;
      else if (shift_done && pending_r && ((state_r == S_DISPLAY) || (state_r == S_BLANK)))
        done_flag_r <= 1'b1;
      else
        done_flag_r <= done_flag_r;
    end
  end

  assign shift_req   = shift_req_r;
  assign shift_addr  = slot_addr_s;
  assign shift_plane = slot_plane_s;
  assign led_blank   = led_blank_r;
  assign led_latch   = led_latch_r;
  assign led_addr    = led_addr_r;
  assign frame_start = frame_start_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_led_bcm_scheduler.sv
// Scoreboard bench for led_bcm_scheduler (PLANES=2, ADDR_BITS=1, BASE_TICKS=2)
// with a behavioural shifter that answers each request after a set delay.
module tb_led_bcm_scheduler;

  typedef struct { int addr; int plane; bit is_start; } shift_exp_t;
  typedef struct { int addr; int fs; int on; int gap; } latch_exp_t;

  logic clk = 1'b0;
  logic resetn, enable, shift_done;
  logic shift_req, led_blank, led_latch, frame_start, busy;
  logic [0:0] shift_addr, led_addr, shift_plane;

  shift_exp_t exp_shift_q[$];
  latch_exp_t exp_latch_q[$];
  int n_checks = 0, n_fails = 0;
  int latch_seen = 0, frame_cnt = 0;
  int shift_delay = 5;
  int gap_tab[8];

  always #5 clk = ~clk;

  led_bcm_scheduler #(.PLANES(2), .ADDR_BITS(1), .BASE_TICKS(2)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .shift_req(shift_req), .shift_addr(shift_addr), .shift_plane(shift_plane),
    .shift_done(shift_done), .led_blank(led_blank), .led_latch(led_latch),
    .led_addr(led_addr), .frame_start(frame_start), .busy(busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Shifter model: shift_done pulses shift_delay cycles after shift_req.
  initial begin : shifter
    int cnt;
    cnt = 0;
    shift_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        cnt = 0;
        shift_done = 1'b0;
      end else begin
        shift_done = 1'b0;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) shift_done = 1'b1;
        end
        if (shift_req) cnt = shift_delay;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues a request or a latch.
  initial begin : monitor
    int on_cnt, gap_cnt, exp_on;
    bit prev_blank, prev_latch, prev_busy;
    shift_exp_t se;
    latch_exp_t le;
    on_cnt = 0; gap_cnt = 0; exp_on = -1;
    prev_blank = 1'b1; prev_latch = 1'b0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        on_cnt = 0; gap_cnt = 0; exp_on = -1;
        prev_blank = 1'b1; prev_latch = 1'b0; prev_busy = 1'b0;
      end else begin
        if (shift_req) begin
          if (exp_shift_q.size() == 0) begin
            n_checks++; n_fails++;
            $display("FAIL unexpected_shift_req: got addr=%0d plane=%0d, required no request (t=%0t)",
                     shift_addr, shift_plane, $time);
          end else begin
            se = exp_shift_q.pop_front();
            check("shift_addr", int'(shift_addr), se.addr);
            check("shift_plane", int'(shift_plane), se.plane);
            if (se.is_start) begin
              check("shift_req_first_busy_cycle", int'(prev_busy), 0);
            end else begin
              check("shift_req_after_latch", int'(prev_latch), 1);
              check("shift_req_in_display", int'(led_blank), 0);
            end
          end
        end
        if (led_latch) begin
          if (exp_latch_q.size() == 0) begin
            n_checks++; n_fails++;
            $display("FAIL unexpected_latch: got addr=%0d, required no latch (t=%0t)", led_addr, $time);
          end else begin
            le = exp_latch_q.pop_front();
            check("latch_addr", int'(led_addr), le.addr);
            check("latch_frame_start", int'(frame_start), le.fs);
            check("latch_blank", int'(led_blank), 1);
            if (le.gap >= 0) check("dead_time", gap_cnt, le.gap);
            exp_on = le.on;
          end
          latch_seen++;
          gap_cnt = 0;
          on_cnt = 0;
        end else if (!led_blank) begin
          on_cnt++;
          gap_cnt = 0;
        end else begin
          if (!prev_blank) begin
            if (exp_on >= 0) check("on_time", on_cnt, exp_on);
            exp_on = -1;
          end
          if (busy) gap_cnt++;
        end
        if (frame_start) begin
          frame_cnt++;
          check("frame_start_with_latch", int'(led_latch), 1);
        end
        prev_blank = led_blank;
        prev_latch = led_latch;
        prev_busy  = busy;
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    exp_shift_q.delete();
    exp_latch_q.delete();
    resetn = 1'b1;
    @(negedge clk);
    #1;
  endtask

  // Runs n slots from a fresh reset, dropping enable during the display of slot n-2.
  task automatic run_scenario(input int delay, input int n);
    int base_latch, base_frame, waited;
    shift_exp_t se;
    latch_exp_t le;
    shift_delay = delay;
    do_reset();
    base_frame = frame_cnt;
    base_latch = latch_seen;
    for (int k = 0; k < n; k++) begin
      se.addr = (k / 2) % 2; se.plane = k % 2; se.is_start = (k == 0);
      exp_shift_q.push_back(se);
      le.addr = (k / 2) % 2; le.fs = (k % 4 == 0) ? 1 : 0; le.on = 2 << (k % 2); le.gap = gap_tab[k];
      exp_latch_q.push_back(le);
    end
    enable = 1'b1;
    waited = 0;
    while ((latch_seen - base_latch < n - 1) && (waited < 400)) begin
      @(negedge clk); #1; waited++;
    end
    check("latch_progress", latch_seen - base_latch, n - 1);
    @(negedge clk);
    enable = 1'b0;
    waited = 0;
    while (busy && (waited < 400)) begin
      @(negedge clk); #1; waited++;
    end
    check("idle_busy", int'(busy), 0);
    check("idle_blank", int'(led_blank), 1);
    repeat (10) @(negedge clk);
    #1;
    check("latches_consumed", exp_latch_q.size(), 0);
    check("shifts_consumed", exp_shift_q.size(), 0);
    check("latch_count", latch_seen - base_latch, n);
    check("frame_start_count", frame_cnt - base_frame, (n + 3) / 4);
  endtask

  initial begin : stimulus
    int base_latch, waited;
    shift_exp_t se;
    latch_exp_t le;
    resetn = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_blank", int'(led_blank), 1);
    check("rst_latch", int'(led_latch), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_shift_req", int'(shift_req), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_led_addr", int'(led_addr), 0);

    // Dead-time tables: first entry is the FILL wait, then max(1, delay+1-weight).
    gap_tab = '{6, 4, 2, 4, 2, 4, 2, 4};
    run_scenario(5, 8);
    gap_tab = '{11, 9, 7, 9, 0, 0, 0, 0};
    run_scenario(10, 4);
    gap_tab = '{4, 2, 1, 2, 0, 0, 0, 0};
    run_scenario(3, 4);
    gap_tab = '{2, 1, 1, 0, 0, 0, 0, 0};
    run_scenario(1, 3);

    // Asynchronous reset in the first DISPLAY cycle of slot (0,0).
    shift_delay = 5;
    do_reset();
    se.addr = 0; se.plane = 0; se.is_start = 1'b1; exp_shift_q.push_back(se);
    se.addr = 0; se.plane = 1; se.is_start = 1'b0; exp_shift_q.push_back(se);
    le.addr = 0; le.fs = 1; le.on = -1; le.gap = 6; exp_latch_q.push_back(le);
    base_latch = latch_seen;
    enable = 1'b1;
    waited = 0;
    while ((latch_seen - base_latch < 1) && (waited < 100)) begin
      @(negedge clk); #1; waited++;
    end
    check("rst_run_latch_seen", latch_seen - base_latch, 1);
    @(posedge clk);
    #3;
    check("pre_rst_blank", int'(led_blank), 0);
    check("pre_rst_shift_req", int'(shift_req), 1);
    check("pre_rst_shift_plane", int'(shift_plane), 1);
    resetn = 1'b0;
    #1;
    check("async_rst_blank", int'(led_blank), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_shift_req", int'(shift_req), 0);
    check("async_rst_shift_plane", int'(shift_plane), 0);
    check("async_rst_shift_addr", int'(shift_addr), 0);
    check("async_rst_latch", int'(led_latch), 0);
    check("async_rst_frame_start", int'(frame_start), 0);
    enable = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    #1;
    check("post_rst_idle_busy", int'(busy), 0);
    check("post_rst_idle_blank", int'(led_blank), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
